model: RTL and testbench

- Single-bit input conditioner that sits between an external or foreign-language signal `in` and synchronous logic.
- Cleans X/Z values out of `in`, resynchronises it to `clk`, and debounces it.
- Drives a clean registered `out`, edge pulses, and X/Z diagnostics.
- All outputs are known-valued 0/1 after reset.

---
 rtl/model_pkg.sv | 17 +
 rtl/model_sync.sv | 29 ++
 rtl/model.sv | 89 ++++++++
 tb/tb_model.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/model_pkg.sv
// model_pkg: shared constants and helpers for the input conditioner.
//   SYNC_STAGES_DEF   - default synchroniser depth
//   STABLE_CYCLES_DEF - default debounce length
//   cnt_width()       - debounce counter width, clog2(n+1) with a floor of 1
`timescale 1ns/1ps
package model_pkg;

   localparam int SYNC_STAGES_DEF   = 2;
   localparam int STABLE_CYCLES_DEF = 4;

   function automatic int cnt_width(input int stable_cycles);
      int w;
      w = $clog2(stable_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/model_sync.sv
// model_sync: plain shift chain forming the back end of the synchroniser.
//   clk   - rising-edge clock
//   rst_n - async active-low reset, clears every stage
//   d     - input from the capture flop
//   q     - output of the last stage
`timescale 1ns/1ps
module model_sync #(
   parameter int STAGES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sh_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q <= '0;
      end else begin
         sh_q[0] <= d;
         for (int i = 1; i < STAGES; i++) sh_q[i] <= sh_q[i-1];
      end
   end

   assign q = sh_q[STAGES-1];

endmodule

// File: rtl/model.sv
// model: single-bit input conditioner (X/Z scrub, synchronise, debounce).
//   clk          - rising-edge clock
//   rst_n        - async active-low reset
//   in           - raw input, may carry 0/1/X/Z
//   out          - clean, synchronised, debounced level
//   rise / fall  - one-cycle pulses coincident with out changing
//   in_invalid   - high the cycle after an edge that sampled X/Z
//   invalid_seen - sticky X/Z flag, cleared only by reset
`timescale 1ns/1ps
module model
   import model_pkg::*;
#(
   parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic out,
   output logic rise,
   output logic fall,
   output logic in_invalid,
   output logic invalid_seen
);

   localparam int               CNT_W    = cnt_width(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             stage1_q, stage1_d;
   logic             cand;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             rise_q, fall_q;
   logic             inv_q, seen_q;
   logic             in_valid;

   // 4-state compare: X/Z fails both tests in simulation; synthesis sees
   // a 2-state input and folds this to constant 1.
   assign in_valid = (in === 1'b0) || (in === 1'b1);

   // X/Z freezes the capture flop so the last valid level is kept.
   assign stage1_d = in_valid ? in : stage1_q;

   model_sync #(
      .STAGES (SYNC_STAGES - 1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (stage1_q),
      .q     (cand)
   );

   always_comb begin
      cnt_d = '0;
      out_d = out_q;
      if (cand != out_q) begin
         if (cnt_q == CNT_LAST) out_d = cand;
         else                   cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage1_q <= 1'b0;
         cnt_q    <= '0;
         out_q    <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         inv_q    <= 1'b0;
         seen_q   <= 1'b0;
      end else begin
         stage1_q <= stage1_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         // Pulses are registered alongside out so they line up with it.
         rise_q   <= out_d & ~out_q;
         fall_q   <= ~out_d & out_q;
         inv_q    <= ~in_valid;
         seen_q   <= seen_q | ~in_valid;
      end
   end

   assign out          = out_q;
   assign rise         = rise_q;
   assign fall         = fall_q;
   assign in_invalid   = inv_q;
   assign invalid_seen = seen_q;

endmodule

// File: tb/tb_model.sv
`timescale 1ns/1ps
module tb_model;

   logic clk = 1'b0;
   logic rst_n;
   logic in_s, in_p;
   logic out_s, rise_s, fall_s, inv_s, seen_s;
   logic out_p, rise_p, fall_p, inv_p, seen_p;

   int checks   = 0;
   int failures = 0;
   bit fourstate;

   always #1 clk = ~clk;

   model u_dut (
      .clk (clk), .rst_n (rst_n), .in (in_s),
      .out (out_s), .rise (rise_s), .fall (fall_s),
      .in_invalid (inv_s), .invalid_seen (seen_s)
   );

   model #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) u_par (
      .clk (clk), .rst_n (rst_n), .in (in_p),
      .out (out_p), .rise (rise_p), .fall (fall_p),
      .in_invalid (inv_p), .invalid_seen (seen_p)
   );

   typedef struct {
      logic in;
      logic out;
      logic rise;
      logic fall;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic add(input int n, input logic i, input logic o, input logic r, input logic f);
      vec_t v;
      v.in = i; v.out = o; v.rise = r; v.fall = f;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   // Drive at a negedge, let one rising edge pass, sample at the next negedge.
   task automatic cyc(input string nm, input logic v, input logic eo, input logic er, input logic ef);
      in_s = v;
      @(posedge clk);
      @(negedge clk);
      chk({nm, ".out"},  out_s,  eo);
      chk({nm, ".rise"}, rise_s, er);
      chk({nm, ".fall"}, fall_s, ef);
   endtask

   task automatic cycp(input string nm, input logic v, input logic eo, input logic er, input logic ef);
      in_p = v;
      @(posedge clk);
      @(negedge clk);
      chk({nm, ".out"},  out_p,  eo);
      chk({nm, ".rise"}, rise_p, er);
      chk({nm, ".fall"}, fall_p, ef);
   endtask

   initial begin
      logic probe;
      logic xv, zv;
      probe = 1'bx;
      fourstate = $isunknown(probe);
      xv = fourstate ? 1'bx : 1'b1;
      zv = fourstate ? 1'bz : 1'b1;

      // Reset asserted with in=1: everything low before any edge.
      rst_n = 1'b0; in_s = 1'b1; in_p = 1'b0;
      #0.5;
      chk("rst.out",  out_s,  1'b0);
      chk("rst.rise", rise_s, 1'b0);
      chk("rst.fall", fall_s, 1'b0);
      chk("rst.inv",  inv_s,  1'b0);
      chk("rst.seen", seen_s, 1'b0);
      chk("rst.par_out", out_p, 1'b0);
      @(negedge clk);
      @(negedge clk);
      in_s = 1'b0;
      rst_n = 1'b1;

      // Level tracking and glitch rejection, one row per rising edge.
      add(3, 1'b0, 1'b0, 1'b0, 1'b0);
      add(5, 1'b1, 1'b0, 1'b0, 1'b0);   // rise: edges 1..5 no change
      add(1, 1'b1, 1'b1, 1'b1, 1'b0);   // edge 6
      add(2, 1'b1, 1'b1, 1'b0, 1'b0);
      add(5, 1'b0, 1'b1, 1'b0, 1'b0);   // fall: edges 1..5 hold
      add(1, 1'b0, 1'b0, 1'b0, 1'b1);   // edge 6
      add(2, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2, 1'b1, 1'b0, 1'b0, 1'b0);   // two-cycle glitch
      add(8, 1'b0, 1'b0, 1'b0, 1'b0);
      foreach (vecs[i]) cyc($sformatf("vec%0d", i), vecs[i].in, vecs[i].out, vecs[i].rise, vecs[i].fall);
      chk("tbl.seen", seen_s, 1'b0);

      // X/Z hold from out=1.
      for (int k = 1; k <= 8; k++)
         cyc($sformatf("xz_up%0d", k), 1'b1, k >= 6, k == 6, 1'b0);
      if (!fourstate) $display("note: 2-state simulator, X/Z inputs cannot be represented");
      for (int k = 0; k < 5; k++) begin
         cyc($sformatf("x%0d", k), xv, 1'b1, 1'b0, 1'b0);
         chk($sformatf("x%0d.inv", k), inv_s, fourstate);
      end
      for (int k = 0; k < 5; k++) begin
         cyc($sformatf("z%0d", k), zv, 1'b1, 1'b0, 1'b0);
         chk($sformatf("z%0d.inv", k), inv_s, fourstate);
      end
      chk("xz.seen", seen_s, fourstate);
      // in=0 for four edges, then X on edges 5 and 6: the count still completes.
      for (int k = 1; k <= 4; k++) begin
         cyc($sformatf("xz_dn%0d", k), 1'b0, 1'b1, 1'b0, 1'b0);
         chk($sformatf("xz_dn%0d.inv", k), inv_s, 1'b0);
      end
      cyc("xz_dn5", fourstate ? 1'bx : 1'b0, 1'b1, 1'b0, 1'b0);
      chk("xz_dn5.inv", inv_s, fourstate);
      cyc("xz_dn6", fourstate ? 1'bx : 1'b0, 1'b0, 1'b0, 1'b1);
      chk("xz_dn6.inv", inv_s, fourstate);
      for (int k = 7; k <= 8; k++) begin
         cyc($sformatf("xz_dn%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
         chk($sformatf("xz_dn%0d.inv", k), inv_s, 1'b0);
         chk($sformatf("xz_dn%0d.seen", k), seen_s, fourstate);
      end

      // Reset mid-count.
      for (int k = 1; k <= 4; k++)
         cyc($sformatf("mid%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #0.3;
      chk("mid_rst.out",  out_s,  1'b0);
      chk("mid_rst.seen", seen_s, 1'b0);
      chk("mid_rst.inv",  inv_s,  1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 7; k++)
         cyc($sformatf("rel%0d", k), 1'b1, k >= 6, k == 6, 1'b0);

      // Reset while out=1 must drop it without waiting for an edge.
      rst_n = 1'b0;
      #0.3;
      chk("async_rst.out",  out_s,  1'b0);
      chk("async_rst.rise", rise_s, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      in_s = 1'b0;

      // SYNC_STAGES=3, STABLE_CYCLES=1: four-edge latency.
      cycp("par_idle", 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 5; k++)
         cycp($sformatf("par_up%0d", k), 1'b1, k >= 4, k == 4, 1'b0);
      for (int k = 1; k <= 5; k++)
         cycp($sformatf("par_dn%0d", k), 1'b0, k < 4, 1'b0, k == 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      failures++;
      $display("FAIL timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
